// File: rtl/nec_pkg.sv
// rtl/nec_pkg.sv - shared NEC IR state encoding and protocol timing constants
package nec_pkg;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_LEAD_MARK  = 3'd1;
    localparam logic [2:0] S_LEAD_SPACE = 3'd2;
    localparam logic [2:0] S_RPT_SPACE  = 3'd3;
    localparam logic [2:0] S_BIT_MARK   = 3'd4;
    localparam logic [2:0] S_BIT_SPACE  = 3'd5;
    localparam logic [2:0] S_STOP_MARK  = 3'd6;
    localparam logic [2:0] S_GAP        = 3'd7;

    // Protocol durations in microseconds
    localparam int unsigned T_LEAD_MARK  = 9000;
    localparam int unsigned T_LEAD_SPACE = 4500;
    localparam int unsigned T_RPT_SPACE  = 2250;
    localparam int unsigned T_BIT_MARK   = 560;
    localparam int unsigned T_ZERO_SPACE = 560;
    localparam int unsigned T_ONE_SPACE  = 1690;
    localparam int unsigned T_STOP       = 560;

    function automatic logic is_mark(input logic [2:0] s);
        return (s == S_LEAD_MARK) || (s == S_BIT_MARK) || (s == S_STOP_MARK);
    endfunction

endpackage

// File: rtl/nec_us_tick.sv
// rtl/nec_us_tick.sv - divide-by-CLK_PER_US tick pulse generator with restart
module nec_us_tick #(
    parameter int unsigned CLK_PER_US = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_PER_US - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST) && !clr;

endmodule

// File: rtl/nec_ir_encode.sv
// rtl/nec_ir_encode.sv - NEC IR frame / repeat-code transmitter with 38 kHz carrier
module nec_ir_encode
    import nec_pkg::*;
#(
    parameter int unsigned CLK_PER_US    = 100,
    parameter int unsigned CARRIER_HALF  = 1316,
    parameter int unsigned GAP_US        = 40000,
    parameter int unsigned LEAD_MARK_US  = T_LEAD_MARK,
    parameter int unsigned LEAD_SPACE_US = T_LEAD_SPACE,
    parameter int unsigned RPT_SPACE_US  = T_RPT_SPACE,
    parameter int unsigned BIT_MARK_US   = T_BIT_MARK,
    parameter int unsigned ZERO_SPACE_US = T_ZERO_SPACE,
    parameter int unsigned ONE_SPACE_US  = T_ONE_SPACE,
    parameter int unsigned STOP_US       = T_STOP
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rpt,
    input  logic [7:0] addr,
    input  logic [7:0] cmd,
    output logic       busy,
    output logic       done,
    output logic       ir_env,
    output logic       ir_carrier,
    output logic       ir_n
);

    localparam int unsigned CCW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
    localparam logic [CCW-1:0] CAR_LAST = CCW'(CARRIER_HALF - 1);

    logic [2:0]     state_q, state_d;
    logic [15:0]    dur_q, dur_d;
    logic [31:0]    sr_q, sr_d;
    logic [4:0]     idx_q, idx_d;
    logic           rpt_q, rpt_d;
    logic           env_q;
    logic [CCW-1:0] car_cnt_q;
    logic           car_q;
    logic           tick;
    logic           accept;
    logic           dur_end;

    assign accept  = start && (state_q == S_IDLE);
    assign dur_end = tick && (dur_q == 16'd0);

    // Restarting the divider on accept makes the leader exact to within one clk
    nec_us_tick #(.CLK_PER_US(CLK_PER_US)) u_us_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .tick (tick)
    );

    // Counter holds remaining ticks minus one; state ends on the tick seen at zero
    function automatic logic [15:0] load_of(input logic [2:0] s, input logic one);
        case (s)
            S_LEAD_MARK:  return 16'(LEAD_MARK_US - 1);
            S_LEAD_SPACE: return 16'(LEAD_SPACE_US - 1);
            S_RPT_SPACE:  return 16'(RPT_SPACE_US - 1);
            S_BIT_MARK:   return 16'(BIT_MARK_US - 1);
            S_BIT_SPACE:  return one ? 16'(ONE_SPACE_US - 1) : 16'(ZERO_SPACE_US - 1);
            S_STOP_MARK:  return 16'(STOP_US - 1);
            S_GAP:        return 16'(GAP_US - 1);
            default:      return 16'd0;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        dur_d   = dur_q;
        sr_d    = sr_q;
        idx_d   = idx_q;
        rpt_d   = rpt_q;
        if (accept) begin
            state_d = S_LEAD_MARK;
            rpt_d   = rpt;
            sr_d    = {~cmd, cmd, ~addr, addr};
            idx_d   = 5'd0;
        end else if (state_q != S_IDLE) begin
            if (tick) begin
                dur_d = dur_q - 16'd1;
            end
            if (dur_end) begin
                case (state_q)
                    S_LEAD_MARK:  state_d = rpt_q ? S_RPT_SPACE : S_LEAD_SPACE;
                    S_LEAD_SPACE: begin
                        state_d = S_BIT_MARK;
                        idx_d   = 5'd0;
                    end
                    S_RPT_SPACE:  state_d = S_STOP_MARK;
                    S_BIT_MARK:   state_d = S_BIT_SPACE;
                    S_BIT_SPACE: begin
                        sr_d    = {1'b0, sr_q[31:1]};
                        idx_d   = idx_q + 5'd1;
                        state_d = (idx_q == 5'd31) ? S_STOP_MARK : S_BIT_MARK;
                    end
                    S_STOP_MARK:  state_d = S_GAP;
                    default:      state_d = S_IDLE;
                endcase
            end
        end
        // sr_q[0] is still the bit being sent when BIT_MARK hands over to BIT_SPACE
        if (state_d != state_q) begin
            dur_d = load_of(state_d, sr_q[0]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            dur_q     <= 16'd0;
            sr_q      <= 32'd0;
            idx_q     <= 5'd0;
            rpt_q     <= 1'b0;
            env_q     <= 1'b0;
            car_cnt_q <= '0;
            car_q     <= 1'b1;
        end else begin
            state_q <= state_d;
            dur_q   <= dur_d;
            sr_q    <= sr_d;
            idx_q   <= idx_d;
            rpt_q   <= rpt_d;
            env_q   <= is_mark(state_d);
            // Every mark starts with a full high carrier half-period
            if (!is_mark(state_d) || (state_d != state_q)) begin
                car_cnt_q <= '0;
                car_q     <= 1'b1;
            end else if (car_cnt_q == CAR_LAST) begin
                car_cnt_q <= '0;
                car_q     <= ~car_q;
            end else begin
                car_cnt_q <= car_cnt_q + CCW'(1);
            end
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_GAP) && dur_end && !rst;
    assign ir_env     = env_q;
    assign ir_carrier = env_q && car_q;
    assign ir_n       = ~env_q;

endmodule

// File: tb/tb_nec_ir_encode.sv
// tb/tb_nec_ir_encode.sv - self-checking bench for nec_ir_encode against a segment-list model
module tb_nec_ir_encode;

    localparam int C    = 4;
    localparam int CH   = 3;
    localparam int GAP  = 40;
    localparam int LM   = 90;
    localparam int LS   = 45;
    localparam int RS   = 22;
    localparam int BM   = 6;
    localparam int ZS   = 6;
    localparam int OS   = 17;
    localparam int ST   = 6;
    localparam int LIMIT = 4000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       rpt = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] cmd = 8'h00;
    logic       busy, done, ir_env, ir_carrier, ir_n;

    int checks = 0;
    int errors = 0;

    int   exp_len[$];
    logic exp_lvl[$];
    int   cap_len[$];
    logic cap_lvl[$];
    int   cap_car_err, cap_busy_err, cap_irn_err;
    bit   cap_timeout;

    nec_ir_encode #(
        .CLK_PER_US(C), .CARRIER_HALF(CH), .GAP_US(GAP),
        .LEAD_MARK_US(LM), .LEAD_SPACE_US(LS), .RPT_SPACE_US(RS),
        .BIT_MARK_US(BM), .ZERO_SPACE_US(ZS), .ONE_SPACE_US(OS), .STOP_US(ST)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .rpt(rpt), .addr(addr), .cmd(cmd),
        .busy(busy), .done(done), .ir_env(ir_env), .ir_carrier(ir_carrier), .ir_n(ir_n)
    );

    always #5 clk = ~clk;

    // Expected envelope as alternating (level, cycles) runs, ending with the gap
    task automatic build_exp(input logic r, input logic [7:0] a, input logic [7:0] c);
        logic b;
        exp_len.delete();
        exp_lvl.delete();
        exp_len.push_back(LM * C); exp_lvl.push_back(1'b1);
        if (r) begin
            exp_len.push_back(RS * C); exp_lvl.push_back(1'b0);
        end else begin
            exp_len.push_back(LS * C); exp_lvl.push_back(1'b0);
            for (int i = 0; i < 32; i++) begin
                case (i / 8)
                    0:       b = a[i % 8];
                    1:       b = ~a[i % 8];
                    2:       b = c[i % 8];
                    default: b = ~c[i % 8];
                endcase
                exp_len.push_back(BM * C); exp_lvl.push_back(1'b1);
                exp_len.push_back((b ? OS : ZS) * C); exp_lvl.push_back(1'b0);
            end
        end
        exp_len.push_back(ST * C); exp_lvl.push_back(1'b1);
        exp_len.push_back(GAP * C); exp_lvl.push_back(1'b0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Records the envelope from the first cycle after acceptance up to the done cycle
    task automatic capture(input int poke_cycle, input logic [7:0] poke_cmd);
        int   run = 0;
        int   cyc = 0;
        logic lvl;
        logic exp_car;
        cap_len.delete();
        cap_lvl.delete();
        cap_car_err = 0; cap_busy_err = 0; cap_irn_err = 0; cap_timeout = 0;
        lvl = ir_env;
        forever begin
            if (cyc == poke_cycle) begin
                start = 1'b1;
                cmd   = poke_cmd;
                addr  = ~addr;
            end else begin
                start = 1'b0;
            end
            if (ir_env !== lvl) begin
                cap_len.push_back(run); cap_lvl.push_back(lvl);
                lvl = ir_env;
                run = 0;
            end
            exp_car = ir_env && (((run / CH) % 2) == 0);
            if (ir_carrier !== exp_car) cap_car_err++;
            if (busy !== 1'b1) cap_busy_err++;
            if (ir_n !== ~ir_env) cap_irn_err++;
            run++;
            if (done === 1'b1) begin
                cap_len.push_back(run); cap_lvl.push_back(lvl);
                break;
            end
            if (cyc > LIMIT) begin
                cap_timeout = 1;
                break;
            end
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_frame(input string name, input logic r, input logic [7:0] a,
                              input logic [7:0] c, input int poke_cycle);
        wait_idle();
        build_exp(r, a, c);
        rpt = r; addr = a; cmd = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        capture(poke_cycle, c ^ 8'h5A);
        checks++;
        if (cap_timeout !== 1'b0) begin
            errors++;
            $display("FAIL %s done_timeout got=%0d want=0", name, cap_timeout);
        end
        checks++;
        if (cap_len.size() !== exp_len.size()) begin
            errors++;
            $display("FAIL %s segment_count got=%0d want=%0d", name, cap_len.size(), exp_len.size());
        end else begin
            for (int i = 0; i < exp_len.size(); i++) begin
                checks++;
                if (cap_len[i] !== exp_len[i] || cap_lvl[i] !== exp_lvl[i]) begin
                    errors++;
                    $display("FAIL %s seg%0d got=%0d/%0d want=%0d/%0d", name, i,
                             cap_lvl[i], cap_len[i], exp_lvl[i], exp_len[i]);
                end
            end
        end
        checks++;
        if (cap_car_err !== 0) begin
            errors++;
            $display("FAIL %s carrier_cycles got=%0d want=0", name, cap_car_err);
        end
        checks++;
        if (cap_busy_err !== 0) begin
            errors++;
            $display("FAIL %s busy_low_cycles got=%0d want=0", name, cap_busy_err);
        end
        checks++;
        if (cap_irn_err !== 0) begin
            errors++;
            $display("FAIL %s ir_n_cycles got=%0d want=0", name, cap_irn_err);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s after_done busy/done got=%b%b want=00", name, busy, done);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({busy, done, ir_env, ir_carrier, ir_n} !== 5'b00001) begin
            errors++;
            $display("FAIL reset outputs got=%b want=00001", {busy, done, ir_env, ir_carrier, ir_n});
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, ir_env, ir_carrier, ir_n} !== 5'b00001) begin
            errors++;
            $display("FAIL idle outputs got=%b want=00001", {busy, done, ir_env, ir_carrier, ir_n});
        end
    endtask

    task automatic test_full_frame();
        test_frame("frame_00_45", 1'b0, 8'h00, 8'h45, -1);
        for (int k = 0; k < 3; k++) begin
            test_frame("frame_rand", 1'b0, 8'($urandom), 8'($urandom), -1);
        end
    endtask

    task automatic test_repeat();
        test_frame("repeat", 1'b1, 8'($urandom), 8'($urandom), -1);
    endtask

    task automatic test_ignore_start();
        test_frame("ignore_start", 1'b0, 8'h00, 8'h45, int'($urandom_range(10, 2000)));
    endtask

    task automatic test_reset_mid();
        int target = 0;
        wait_idle();
        build_exp(1'b0, 8'hA5, 8'h3C);
        for (int i = 0; i < 27; i++) target += exp_len[i];
        target += int'($urandom_range(0, exp_len[27] - 1));
        rpt = 1'b0; addr = 8'hA5; cmd = 8'h3C; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < target; i++) @(negedge clk);
        checks++;
        if (ir_env !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid in_bit12_space env/busy got=%b%b want=01", ir_env, busy);
        end
        rst = 1'b1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid done_during_rst got=%b want=0", done);
        end
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({ir_n, busy, ir_carrier, done} !== 4'b1000) begin
            errors++;
            $display("FAIL rst_mid after_rst ir_n/busy/car/done got=%b want=1000",
                     {ir_n, busy, ir_carrier, done});
        end
        test_frame("after_rst", 1'b0, 8'h12, 8'hF0, -1);
    endtask

    task automatic test_back_to_back();
        int  dones = 0;
        int  low_run = 0;
        int  n = 0;
        bit  measured = 0;
        bit  after_done = 0;
        wait_idle();
        rpt = 1'b0; addr = 8'($urandom); cmd = 8'($urandom); start = 1'b1;
        while (n < 3 * LIMIT) begin
            @(negedge clk);
            n++;
            if (after_done) begin
                after_done = 0;
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b busy_after_done got=%b want=0", busy);
                end
            end
            if (done === 1'b1) begin
                dones++;
                after_done = 1;
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b busy_at_done got=%b want=1", busy);
                end
            end
            if (ir_env === 1'b0) begin
                low_run++;
            end else begin
                if (dones == 1 && !measured) begin
                    measured = 1;
                    checks++;
                    if (low_run !== GAP * C + 1) begin
                        errors++;
                        $display("FAIL b2b gap_cycles got=%0d want=%0d", low_run, GAP * C + 1);
                    end
                end
                low_run = 0;
            end
            if (dones == 2) break;
        end
        start = 1'b0;
        checks++;
        if (dones !== 2 || !measured) begin
            errors++;
            $display("FAIL b2b frames_seen got=%0d want=2", dones);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        test_full_frame();
        test_repeat();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
